// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, double-flop synchronized input, one-deep
// holding register with empty, framing-error and sticky overrun status.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 rxclk,
  input  logic                 reset,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  input  logic                 uld_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_empty_q, rx_empty_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic                 rx_overrun_q, rx_overrun_d;
  logic                 frame_done;

  always_ff @(posedge rxclk) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bcnt_q         <= '0;
      shift_q        <= '0;
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      rx_data_q      <= '0;
      rx_empty_q     <= 1'b1;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bcnt_q         <= bcnt_d;
      shift_q        <= shift_d;
      rx_meta_q      <= rx_meta_d;
      rx_s_q         <= rx_s_d;
      rx_data_q      <= rx_data_d;
      rx_empty_q     <= rx_empty_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_overrun_q   <= rx_overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    rx_meta_d  = rx_in;
    rx_s_d     = rx_meta_q;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end
      START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            bcnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d           = '0;
          shift_d[bcnt_q] = rx_s_q;
          if (bcnt_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Disabling discards any frame in flight, including one about to complete.
    if (!rx_enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      frame_done = 1'b0;
    end
  end

  always_comb begin
    rx_data_d      = rx_data_q;
    rx_empty_d     = rx_empty_q;
    rx_frame_err_d = rx_frame_err_q;
    rx_overrun_d   = rx_overrun_q;

    // A completing frame beats a same-cycle unload; the unload still consumes the old byte.
    if (frame_done) begin
      rx_data_d      = shift_q;
      rx_frame_err_d = ~rx_s_q;
      rx_empty_d     = 1'b0;
      if (uld_rx_data) begin
        rx_overrun_d = 1'b0;
      end else if (!rx_empty_q) begin
        rx_overrun_d = 1'b1;
      end
    end else if (uld_rx_data) begin
      rx_empty_d   = 1'b1;
      rx_overrun_d = 1'b0;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_empty     = rx_empty_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_overrun   = rx_overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed 8N1 scenarios followed by random
// frames, compared against a frame-level model of the holding register.
module tb_uart_rx;

  localparam int NB    = 8;
  localparam int OS    = 16;
  localparam int FRAME = (NB + 2) * OS;
  // Loop index of the completion edge: rx_in is first sampled at edge 1, then
  // two synchronizer edges and the IDLE decision edge, then OS/2+(NB+1)*OS.
  localparam int DONE_I = 2 + OS / 2 + (NB + 1) * OS;

  logic          rxclk = 1'b0;
  logic          reset;
  logic          rx_enable;
  logic          rx_in;
  logic          uld_rx_data;
  logic [NB-1:0] rx_data;
  logic          rx_empty;
  logic          rx_frame_err;
  logic          rx_overrun;

  int compared   = 0;
  int mismatched = 0;

  logic [NB-1:0] exp_data;
  logic          exp_empty;
  logic          exp_ferr;
  logic          exp_ovr;

  uart_rx #(.DATA_BITS(NB), .OVERSAMPLE(OS)) dut (
    .rxclk       (rxclk),
    .reset       (reset),
    .rx_enable   (rx_enable),
    .rx_in       (rx_in),
    .uld_rx_data (uld_rx_data),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
  );

  always #5 rxclk = ~rxclk;

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) tick();
  endtask

  // Host-visible model: what the holding register must contain after events.
  task automatic modelReset();
    exp_data  = '0;
    exp_empty = 1'b1;
    exp_ferr  = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  task automatic modelComplete(input logic [NB-1:0] data, input logic stop_bit, input logic uld);
    if (uld) exp_ovr = 1'b0;
    else if (!exp_empty) exp_ovr = 1'b1;
    exp_data  = data;
    exp_ferr  = ~stop_bit;
    exp_empty = 1'b0;
  endtask

  task automatic modelUnload();
    exp_empty = 1'b1;
    exp_ovr   = 1'b0;
  endtask

  function automatic logic lineLevel(input logic [NB-1:0] data, input logic stop_bit, input int i);
    if (i < OS) return 1'b0;
    if (i < (NB + 1) * OS) return data[(i - OS) / OS];
    return stop_bit;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".rx_data"}, 32'(rx_data), 32'(exp_data));
    checkOutput({tag, ".rx_empty"}, 32'(rx_empty), 32'(exp_empty));
    checkOutput({tag, ".rx_frame_err"}, 32'(rx_frame_err), 32'(exp_ferr));
    checkOutput({tag, ".rx_overrun"}, 32'(rx_overrun), 32'(exp_ovr));
  endtask

  task automatic unloadPulse(input string tag);
    uld_rx_data = 1'b1;
    tick();
    uld_rx_data = 1'b0;
    modelUnload();
    checkAll({tag, ".unload"});
  endtask

  // Drives one full frame; checks rx_empty one edge before completion and all
  // outputs right after the completion edge.
  task automatic applyStimulus(input string tag, input logic [NB-1:0] data,
                               input logic stop_bit, input logic uld_at_done);
    for (int i = 0; i < FRAME; i++) begin
      rx_in       = lineLevel(data, stop_bit, i);
      uld_rx_data = uld_at_done && (i == DONE_I);
      tick();
      if (i == DONE_I - 1) checkOutput({tag, ".pre_done_empty"}, 32'(rx_empty), 32'(exp_empty));
      if (i == DONE_I) begin
        modelComplete(data, stop_bit, uld_at_done);
        checkAll(tag);
      end
    end
    uld_rx_data = 1'b0;
    rx_in       = 1'b1;
  endtask

  initial begin
    logic [NB-1:0] data;
    logic          stop_bit;
    logic          uld_done;
    int            gap;

    reset       = 1'b0;
    rx_enable   = 1'b0;
    rx_in       = 1'b1;
    uld_rx_data = 1'b0;
    modelReset();
    repeat (3) tick();
    checkAll("reset");

    reset     = 1'b1;
    rx_enable = 1'b1;
    idle(5);

    $display("[TB] normal frame 0xA5");
    applyStimulus("normal", 8'hA5, 1'b1, 1'b0);
    idle(4);
    unloadPulse("normal");

    $display("[TB] false start glitch");
    rx_in = 1'b0;
    repeat (4) tick();
    idle(30);
    checkAll("false_start");
    applyStimulus("after_glitch", 8'h3C, 1'b1, 1'b0);
    idle(4);
    unloadPulse("after_glitch");

    $display("[TB] framing error");
    applyStimulus("frame_err", 8'hFF, 1'b0, 1'b0);
    idle(10);
    applyStimulus("frame_ok", 8'h00, 1'b1, 1'b0);
    idle(2);
    unloadPulse("frame_ok");

    $display("[TB] overrun");
    applyStimulus("ovr_first", 8'h11, 1'b1, 1'b0);
    applyStimulus("ovr_second", 8'h22, 1'b1, 1'b0);
    idle(3);
    unloadPulse("ovr");

    $display("[TB] simultaneous unload and completion");
    applyStimulus("simul_first", 8'h11, 1'b1, 1'b0);
    applyStimulus("simul_second", 8'h22, 1'b1, 1'b1);
    idle(3);

    $display("[TB] reset mid-frame");
    applyStimulus("pre_abort", 8'h11, 1'b1, 1'b0);
    data = 8'hF8 | 8'($urandom_range(0, 7));
    for (int i = 0; i < FRAME; i++) begin
      rx_in = lineLevel(data, 1'b1, i);
      reset = (i != 3 * OS + OS + 6) ? 1'b1 : 1'b0;
      tick();
      if (reset == 1'b0) begin
        modelReset();
        checkAll("abort_reset");
      end
    end
    reset = 1'b1;
    idle(200);
    checkAll("abort_reset_after");

    $display("[TB] disable mid-frame");
    applyStimulus("pre_disable", 8'hFF, 1'b0, 1'b0);
    idle(10);
    data = 8'($urandom);
    for (int i = 0; i < FRAME; i++) begin
      rx_in = lineLevel(data, 1'b1, i);
      if (i == 3 * OS + OS + 6) rx_enable = 1'b0;
      tick();
    end
    idle(200);
    checkAll("disable_retained");
    unloadPulse("disabled");
    rx_enable = 1'b1;
    idle(5);

    $display("[TB] random frames");
    for (int f = 0; f < 24; f++) begin
      data     = 8'($urandom);
      stop_bit = ($urandom_range(0, 3) != 0);
      uld_done = ($urandom_range(0, 3) == 0);
      gap      = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40));
      // A low stop bit holds the line low past completion; give it time to be rejected.
      if (!stop_bit && gap < 8) gap = 8;
      applyStimulus($sformatf("rand%0d", f), data, stop_bit, uld_done);
      if (gap >= 4 && $urandom_range(0, 1) == 1) begin
        idle(2);
        unloadPulse($sformatf("rand%0d", f));
        idle(gap - 3);
      end else begin
        idle(gap);
      end
    end
    idle(5);
    checkAll("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
